// File: rtl/cache_types_pkg.sv
// Shared cache types: line/beat geometry and the line-adaptor state encoding.
package cache_types_pkg;

  localparam int LINE_BITS   = 256;
  localparam int BURST_BITS  = 64;
  localparam int BEATS       = LINE_BITS / BURST_BITS;
  localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_BURST = 3'd1,
    RD_DONE  = 3'd2,
    WR_BURST = 3'd3,
    WR_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Bridges whole-line cache requests to BEATS-beat memory bursts, assembling
// read lines beat by beat and slicing write-back lines into beats.
//
// state    | meaning
// IDLE     | waiting for read_i / write_i (read wins when both are high)
// RD_BURST | read_o high, capturing one beat per resp_i
// RD_DONE  | resp_o pulse, line_o holds the assembled line
// WR_BURST | write_o high, presenting one beat per resp_i
// WR_DONE  | resp_o pulse for the write-back
module cacheline_adaptor
  import cache_types_pkg::state_e, cache_types_pkg::IDLE, cache_types_pkg::RD_BURST,
         cache_types_pkg::RD_DONE, cache_types_pkg::WR_BURST, cache_types_pkg::WR_DONE;
#(
  parameter int LINE_BITS  = cache_types_pkg::LINE_BITS,
  parameter int BURST_BITS = cache_types_pkg::BURST_BITS,
  parameter int ADDR_BITS  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_BITS-1:0]  address_i,
  input  logic                  read_i,
  input  logic                  write_i,
  input  logic [LINE_BITS-1:0]  line_i,
  output logic [LINE_BITS-1:0]  line_o,
  output logic                  resp_o,
  output logic [ADDR_BITS-1:0]  address_o,
  output logic                  read_o,
  output logic                  write_o,
  output logic [BURST_BITS-1:0] burst_o,
  input  logic [BURST_BITS-1:0] burst_i,
  input  logic                  resp_i
);

  localparam int BEATS       = LINE_BITS / BURST_BITS;
  localparam int K_BITS      = $clog2(BEATS);
  localparam int OFFSET_BITS = cache_types_pkg::OFFSET_BITS;
  localparam logic [K_BITS-1:0] LAST_K = K_BITS'(BEATS - 1);

  state_e                 state_q, state_d;
  logic [K_BITS-1:0]      k_q, k_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [LINE_BITS-1:0]   wline_q, wline_d;
  logic [LINE_BITS-1:0]   rline_q, rline_d;
  logic                   read_q, read_d;
  logic                   write_q, write_d;
  logic                   resp_q, resp_d;
  logic [ADDR_BITS-1:0]   addr_aligned;

  assign addr_aligned = {address_i[ADDR_BITS-1:OFFSET_BITS], OFFSET_BITS'(0)};

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    unique case (state_q)
      IDLE: begin
        if (read_i) begin
          addr_d  = addr_aligned;
          k_d     = '0;
          state_d = RD_BURST;
        end else if (write_i) begin
          addr_d  = addr_aligned;
          wline_d = line_i;
          k_d     = '0;
          state_d = WR_BURST;
        end
      end
      RD_BURST: begin
        if (resp_i) begin
          rline_d[int'(k_q)*BURST_BITS +: BURST_BITS] = burst_i;
          k_d = k_q + 1'b1;
          if (k_q == LAST_K) state_d = RD_DONE;
        end
      end
      WR_BURST: begin
        if (resp_i) begin
          k_d = k_q + 1'b1;
          if (k_q == LAST_K) state_d = WR_DONE;
        end
      end
      RD_DONE, WR_DONE: state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  // Handshake outputs are flops loaded from the next state, so they change
  // exactly on state transitions and never follow the cache inputs directly.
  always_comb begin
    read_d  = (state_d == RD_BURST);
    write_d = (state_d == WR_BURST);
    resp_d  = (state_d == RD_DONE) || (state_d == WR_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
    end
  end

  assign line_o    = rline_q;
  assign resp_o    = resp_q;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign burst_o   = wline_q[int'(k_q)*BURST_BITS +: BURST_BITS];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: reads, write-backs, gapped beats,
// mid-burst reset, back-to-back and simultaneous requests.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  address_i;
  logic         read_i, write_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o, write_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic         resp_i;

  int errors = 0;
  int checks = 0;
  int overlap_cnt = 0;
  int resp_cnt = 0;

  localparam logic [63:0] B0 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B1 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B2 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B3 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] D0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D1 = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] D2 = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] D3 = 64'hCAFE_F00D_8000_0000;

  cacheline_adaptor dut (
    .clk(clk), .rst(rst), .address_i(address_i), .read_i(read_i),
    .write_i(write_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
    .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .burst_o(burst_o), .burst_i(burst_i), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (read_o && write_o) overlap_cnt++;
    if (resp_o) resp_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; read_i = 0; write_i = 0; resp_i = 0;
    address_i = 32'hFFFF_FFFF; line_i = '1; burst_i = '1;
    step(); step();
    checks++; if (read_o !== 1'b0) begin errors++; $display("FAIL reset_read_o got=%b exp=0", read_o); end
    checks++; if (write_o !== 1'b0) begin errors++; $display("FAIL reset_write_o got=%b exp=0", write_o); end
    checks++; if (resp_o !== 1'b0) begin errors++; $display("FAIL reset_resp_o got=%b exp=0", resp_o); end
    checks++; if (address_o !== 32'h0) begin errors++; $display("FAIL reset_address_o got=%h exp=0", address_o); end
    checks++; if (line_o !== 256'h0) begin errors++; $display("FAIL reset_line_o got=%h exp=0", line_o); end
    checks++; if (burst_o !== 64'h0) begin errors++; $display("FAIL reset_burst_o got=%h exp=0", burst_o); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_read();
    logic [63:0] beats [4];
    beats[0] = B0; beats[1] = B1; beats[2] = B2; beats[3] = B3;
    address_i = 32'h0000_1234; read_i = 1'b1;
    step();
    checks++; if (read_o !== 1'b1) begin errors++; $display("FAIL read_start_read_o got=%b exp=1", read_o); end
    checks++; if (address_o !== 32'h0000_1220) begin errors++; $display("FAIL read_address_o got=%h exp=00001220", address_o); end
    for (int i = 0; i < 4; i++) begin
      burst_i = beats[i]; resp_i = 1'b1;
      step();
      if (i < 3) begin
        checks++; if (resp_o !== 1'b0 || read_o !== 1'b1) begin errors++; $display("FAIL read_mid_beat%0d resp_o=%b read_o=%b exp resp_o=0 read_o=1", i, resp_o, read_o); end
      end
    end
    resp_i = 1'b0; read_i = 1'b0; burst_i = '0;
    checks++; if (resp_o !== 1'b1) begin errors++; $display("FAIL read_resp_latency got=%b exp=1", resp_o); end
    checks++; if (read_o !== 1'b0) begin errors++; $display("FAIL read_done_read_o got=%b exp=0", read_o); end
    checks++; if (line_o !== {B3, B2, B1, B0}) begin errors++; $display("FAIL read_line got=%h exp=%h", line_o, {B3, B2, B1, B0}); end
    step();
    checks++; if (resp_o !== 1'b0) begin errors++; $display("FAIL read_resp_one_cycle got=%b exp=0", resp_o); end
    checks++; if (line_o !== {B3, B2, B1, B0}) begin errors++; $display("FAIL read_line_hold got=%h exp=%h", line_o, {B3, B2, B1, B0}); end
  endtask

  task automatic test_idle_resp();
    resp_i = 1'b1; burst_i = 64'h9999_9999_9999_9999;
    step(); step();
    resp_i = 1'b0;
    checks++; if (line_o !== {B3, B2, B1, B0}) begin errors++; $display("FAIL idle_resp_line got=%h exp=%h", line_o, {B3, B2, B1, B0}); end
    checks++; if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0) begin errors++; $display("FAIL idle_resp_outputs resp_o=%b read_o=%b write_o=%b exp all 0", resp_o, read_o, write_o); end
  endtask

  task automatic test_write();
    logic [63:0] d [4];
    logic [3:0]  pat;
    int          k;
    d[0] = D0; d[1] = D1; d[2] = D2; d[3] = D3;
    pat = 4'b0000;
    address_i = 32'hABCD_EF7F; line_i = {D3, D2, D1, D0}; write_i = 1'b1;
    step();
    line_i = '0;
    checks++; if (write_o !== 1'b1 || read_o !== 1'b0) begin errors++; $display("FAIL write_start write_o=%b read_o=%b exp 1/0", write_o, read_o); end
    checks++; if (address_o !== 32'hABCD_EF60) begin errors++; $display("FAIL write_address_o got=%h exp=abcdef60", address_o); end
    // beat pattern with a gap after the second beat: 1,1,0,1,1
    k = 0;
    for (int c = 0; c < 5; c++) begin
      resp_i = (c != 2);
      checks++; if (burst_o !== d[k]) begin errors++; $display("FAIL write_beat%0d got=%h exp=%h", k, burst_o, d[k]); end
      step();
      if (c != 2) k++;
      if (k < 4) begin
        checks++; if (write_o !== 1'b1 || resp_o !== 1'b0) begin errors++; $display("FAIL write_hold c%0d write_o=%b resp_o=%b exp 1/0", c, write_o, resp_o); end
      end
    end
    resp_i = 1'b0; write_i = 1'b0;
    checks++; if (resp_o !== 1'b1 || write_o !== 1'b0) begin errors++; $display("FAIL write_done resp_o=%b write_o=%b exp 1/0", resp_o, write_o); end
    step();
    checks++; if (resp_o !== 1'b0) begin errors++; $display("FAIL write_resp_one_cycle got=%b exp=0", resp_o); end
    checks++; if (line_o !== {B3, B2, B1, B0}) begin errors++; $display("FAIL write_line_o_stable got=%h exp=%h", line_o, {B3, B2, B1, B0}); end
    if (pat != 4'b0000) $display("pattern unused");
  endtask

  task automatic test_gapped();
    logic        pat [7];
    logic [63:0] beats [4];
    int          k;
    beats[0] = 64'hA5A5_0000_0000_0001; beats[1] = 64'h5A5A_0000_0000_0002;
    beats[2] = 64'h0F0F_0000_0000_0003; beats[3] = 64'hF0F0_0000_0000_0004;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 0; pat[6] = 1;
    address_i = 32'h0000_0040; read_i = 1'b1;
    step();
    k = 0;
    for (int c = 0; c < 7; c++) begin
      checks++; if (read_o !== 1'b1) begin errors++; $display("FAIL gapped_read_o c%0d got=%b exp=1", c, read_o); end
      resp_i = pat[c];
      burst_i = pat[c] ? beats[k] : 64'hBAD0_BAD0_BAD0_BAD0;
      step();
      if (pat[c]) k++;
    end
    resp_i = 1'b0; read_i = 1'b0;
    checks++; if (resp_o !== 1'b1 || read_o !== 1'b0) begin errors++; $display("FAIL gapped_done resp_o=%b read_o=%b exp 1/0", resp_o, read_o); end
    checks++; if (line_o !== {beats[3], beats[2], beats[1], beats[0]}) begin errors++; $display("FAIL gapped_line got=%h exp=%h", line_o, {beats[3], beats[2], beats[1], beats[0]}); end
    step();
  endtask

  task automatic test_reset_mid_burst();
    int r0;
    address_i = 32'h0000_2000; read_i = 1'b1;
    step();
    resp_i = 1'b1; burst_i = 64'h7777_7777_7777_7777; step();
    burst_i = 64'h8888_8888_8888_8888; step();
    resp_i = 1'b0; read_i = 1'b0; rst = 1'b1;
    r0 = resp_cnt;
    step();
    checks++; if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl read_o=%b write_o=%b resp_o=%b exp all 0", read_o, write_o, resp_o); end
    checks++; if (address_o !== 32'h0 || line_o !== 256'h0 || burst_o !== 64'h0) begin errors++; $display("FAIL rst_mid_data address_o=%h burst_o=%h exp 0", address_o, burst_o); end
    rst = 1'b0;
    step(); step();
    checks++; if (resp_cnt != r0) begin errors++; $display("FAIL rst_mid_no_resp got=%0d exp=0 pulses", resp_cnt - r0); end
    test_read();
  endtask

  task automatic test_back_to_back();
    int r0, o0, cyc;
    r0 = resp_cnt; o0 = overlap_cnt;
    address_i = 32'h0000_3000; line_i = {D0, D1, D2, D3}; write_i = 1'b1;
    step();
    cyc = 0;
    resp_i = 1'b1;
    while (resp_o !== 1'b1 && cyc < 20) begin step(); cyc++; end
    checks++; if (cyc != 4) begin errors++; $display("FAIL b2b_write_beats got=%0d exp=4 cycles", cyc); end
    // dirty-miss sequence: the read is raised as soon as the write-back responds
    write_i = 1'b0; read_i = 1'b1; address_i = 32'h0000_4010; resp_i = 1'b0;
    step();
    checks++; if (read_o !== 1'b0 || write_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap read_o=%b write_o=%b exp 0/0", read_o, write_o); end
    step();
    checks++; if (read_o !== 1'b1 || address_o !== 32'h0000_4000) begin errors++; $display("FAIL b2b_read_start read_o=%b address_o=%h exp 1/00004000", read_o, address_o); end
    cyc = 0;
    resp_i = 1'b1; burst_i = 64'h5555_5555_5555_5555;
    while (resp_o !== 1'b1 && cyc < 20) begin step(); cyc++; end
    resp_i = 1'b0; read_i = 1'b0;
    checks++; if (cyc != 4) begin errors++; $display("FAIL b2b_read_beats got=%0d exp=4 cycles", cyc); end
    checks++; if (line_o !== {4{64'h5555_5555_5555_5555}}) begin errors++; $display("FAIL b2b_read_line got=%h", line_o); end
    step();
    checks++; if (resp_cnt - r0 != 2) begin errors++; $display("FAIL b2b_resp_pulses got=%0d exp=2", resp_cnt - r0); end
    checks++; if (overlap_cnt != o0) begin errors++; $display("FAIL b2b_overlap got=%0d exp=0", overlap_cnt - o0); end
  endtask

  task automatic test_both_requests();
    address_i = 32'h0000_5000; read_i = 1'b1; write_i = 1'b1; line_i = {D3, D2, D1, D0};
    step();
    checks++; if (read_o !== 1'b1 || write_o !== 1'b0) begin errors++; $display("FAIL both_read_first read_o=%b write_o=%b exp 1/0", read_o, write_o); end
    resp_i = 1'b1; burst_i = 64'h6666_6666_6666_6666;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (write_o !== 1'b0) begin errors++; $display("FAIL both_no_write beat%0d got=%b exp=0", i, write_o); end
    end
    resp_i = 1'b0; read_i = 1'b0;
    checks++; if (resp_o !== 1'b1) begin errors++; $display("FAIL both_read_resp got=%b exp=1", resp_o); end
    step();
    checks++; if (write_o !== 1'b0) begin errors++; $display("FAIL both_write_after_idle got=%b exp=0", write_o); end
    step();
    checks++; if (write_o !== 1'b1 || burst_o !== D0) begin errors++; $display("FAIL both_write_start write_o=%b burst_o=%h exp 1/%h", write_o, burst_o, D0); end
    resp_i = 1'b1;
    for (int i = 0; i < 4; i++) step();
    resp_i = 1'b0; write_i = 1'b0;
    checks++; if (resp_o !== 1'b1 || write_o !== 1'b0) begin errors++; $display("FAIL both_write_done resp_o=%b write_o=%b exp 1/0", resp_o, write_o); end
    step();
  endtask

  initial begin
    test_reset();
    test_read();
    test_idle_resp();
    test_write();
    test_gapped();
    test_reset_mid_burst();
    test_back_to_back();
    test_both_requests();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameter LINE_BITS, default 256, cache line width in bits.
REQ-002 Parameter BURST_BITS, default 64, memory beat width in bits; BEATS = LINE_BITS/BURST_BITS = 4.
REQ-003 Parameter ADDR_BITS, default 32, byte address width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 address_i  input  ADDR_BITS  line address from the cache controller.
REQ-007 read_i  input  1  cache line read request, held high until resp_o.
REQ-008 write_i  input  1  cache line write-back request, held high until resp_o.
REQ-009 line_i  input  LINE_BITS  write-back line data, stable while write_i is high.
REQ-010 line_o  output  LINE_BITS  assembled read line.
REQ-011 resp_o  output  1  one-cycle completion pulse to the cache.
REQ-012 address_o  output  ADDR_BITS  burst address to memory.
REQ-013 read_o  output  1  burst read request to memory.
REQ-014 write_o  output  1  burst write request to memory.
REQ-015 burst_o  output  BURST_BITS  write beat data.
REQ-016 burst_i  input  BURST_BITS  read beat data.
REQ-017 resp_i  input  1  memory beat strobe; one beat is transferred per cycle that resp_i is high.

Function
REQ-018 FSM states: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
REQ-019 IDLE: if read_i is high, latch address_i with bits [4:0] forced to 0, clear the beat counter, and go to RD_BURST; else if write_i is high, latch the address the same way plus line_i, and go to WR_BURST.
REQ-020 If read_i and write_i are both high in IDLE, read is serviced; write_i is then re-sampled after resp_o.
REQ-021 RD_BURST: read_o=1 and address_o=latched address; on each cycle with resp_i=1, store burst_i into line bits [64k+63:64k] (k = beat counter), then increment k.
REQ-022 RD_BURST: exit to RD_DONE on the cycle the beat with k=3 is stored; read_o is low from RD_DONE onward.
REQ-023 RD_DONE: resp_o=1 for exactly one cycle; line_o holds the assembled line; next state IDLE.
REQ-024 WR_BURST: write_o=1, address_o=latched address, burst_o=latched line bits [64k+63:64k]; on resp_i=1 increment k; after beat k=3 go to WR_DONE.
REQ-025 WR_DONE: resp_o=1 for one cycle; next state IDLE.
REQ-026 Beats may be non-consecutive: a cycle with resp_i=0 holds k and keeps the request asserted.
REQ-027 Beat counter is 2 bits and wraps 3->0 only on the final beat.
REQ-028 resp_i in IDLE or a DONE state is ignored; no data is captured.
REQ-029 read_i and write_i are ignored outside IDLE; a new request is accepted no earlier than the cycle after resp_o.
REQ-030 Latency: if the final beat is sampled at cycle N, resp_o is high at N+1; read_o or write_o rises the cycle after acceptance in IDLE.
REQ-031 line_o stays stable from RD_DONE until the next read beat is captured.
REQ-032 address_o, read_o, write_o and burst_o are registered or state-decoded only; there is no combinational path from cache inputs.

Reset
REQ-033 While rst=1, the next state is IDLE, k=0, line_o=0, address_o=0, and read_o=write_o=resp_o=0; burst_o=0.
REQ-034 rst asserted mid-burst aborts the burst; the next cycle shows all outputs at reset values, and no resp_o is issued for the aborted request.

Structure
REQ-035 LINE_BITS, BURST_BITS, BEATS and the state enum reside in the shared cache package cache_types_pkg.
REQ-036 There is no sub-module; the beat counter and line register are inline.

Verification
REQ-037 Read: read_i, address_i=0x0000_1234; memory returns beats 0x11..,0x22..,0x33..,0x44.. on consecutive cycles -> address_o=0x0000_1220, line_o={0x44..,0x33..,0x22..,0x11..}, and resp_o is high exactly one cycle after the 4th beat.
REQ-038 Write: write_i, line_i={D3,D2,D1,D0} -> burst_o shows D0,D1,D2,D3 in order on each resp_i; write_o drops and resp_o pulses once.
REQ-039 Gapped beats: resp_i pattern 1,0,0,1,1,0,1 -> line assembles correctly, and read_o stays high until the 4th beat.
REQ-040 Reset mid-burst: rst after 2 read beats -> outputs are zero the next cycle with no resp_o; a following read completes with correct data.
REQ-041 Back-to-back: write-back immediately followed by read (the cache's dirty-miss sequence) -> two separate bursts, two resp_o pulses, and no overlap of read_o and write_o.
REQ-042 Both read_i and write_i high -> read burst first, and no write_o until after resp_o.
